// File: rtl/seq_det_ctrl.sv
// Run-time controller for a serial Moore sequence detector: programmable pattern,
// arm/disarm, valid-gated sampling, overlap select and a saturating match counter.
module seq_det_ctrl #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1100),
  parameter int               DEF_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             stop,
  input  logic             ip,
  input  logic             ip_valid,
  output logic             op,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_err
);

  localparam logic [3:0]       PW4     = 4'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_hist;
  logic [3:0]       r_len;
  logic [3:0]       r_fill;
  logic             r_ovl;
  logic             r_op;
  logic             r_busy;
  logic             r_err;
  logic             r_sat;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W-1:0] w_hist_nx;
  logic [PAT_W-1:0] w_mask;
  logic [3:0]       w_fill_nx;
  logic             w_match;
  logic             w_len_ok;

  // Next history/fill and the match decision for the bit being sampled this edge
  always_comb begin
    w_hist_nx = {r_hist[PAT_W-2:0], ip};
    w_fill_nx = (r_fill == PW4) ? r_fill : (r_fill + 4'd1);
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    w_match  = ip_valid && (((w_hist_nx ^ r_pat) & w_mask) == '0) && (w_fill_nx >= r_len);
    w_len_ok = (cfg_len != 4'd0) && (cfg_len <= PW4);
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pat   <= DEF_PAT;
      r_len   <= 4'(DEF_LEN);
      r_ovl   <= 1'b1;
      r_hist  <= '0;
      r_fill  <= 4'd0;
      r_op    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_op <= 1'b0;
          if (cfg_we) begin
            // A config write wins over a coincident start
            if (w_len_ok) begin
              r_pat <= cfg_pattern;
              r_len <= cfg_len;
              r_ovl <= cfg_overlap;
              r_err <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_err <= 1'b0;
            if (start) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_hist  <= '0;
              r_fill  <= 4'd0;
              r_cnt   <= '0;
              r_sat   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RUN, ST_HIT: begin
          r_err <= cfg_we;
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_op    <= 1'b0;
          end else if (ip_valid) begin
            r_hist <= w_hist_nx;
            if (w_match) begin
              r_state <= ST_HIT;
              r_op    <= 1'b1;
              r_fill  <= r_ovl ? w_fill_nx : 4'd0;
              if (r_cnt == CNT_MAX) begin
                r_sat <= 1'b1;
              end else begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end else begin
              r_state <= ST_RUN;
              r_op    <= 1'b0;
              r_fill  <= w_fill_nx;
            end
          end else begin
            r_state <= ST_RUN;
            r_op    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_op    <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign op        = r_op;
  assign busy      = r_busy;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomised plus directed bench for seq_det_ctrl, checked against a bit-list model
// of the detector; a second instance with a 2-bit counter exercises saturation.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = 8'd0;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       ip = 1'b0;
  logic       ip_valid = 1'b0;

  logic       op_a, busy_a, sat_a, err_a;
  logic [7:0] cnt_a;
  logic       op_b, busy_b, sat_b, err_b;
  logic [1:0] cnt_b;

  int n_vec = 0;
  int n_err = 0;

  seq_det_ctrl u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .ip(ip), .ip_valid(ip_valid), .op(op_a), .busy(busy_a), .match_cnt(cnt_a),
    .cnt_sat(sat_a), .cfg_err(err_a)
  );

  seq_det_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .ip(ip), .ip_valid(ip_valid), .op(op_b), .busy(busy_b), .match_cnt(cnt_b),
    .cnt_sat(sat_b), .cfg_err(err_b)
  );

  always #5 clk = ~clk;

  // Model: the bits received since arming (or since the last non-overlap match)
  bit         m_armed, m_op, m_err, m_sat8, m_sat2, m_ovl;
  logic [7:0] m_cnt8, m_pat;
  logic [1:0] m_cnt2;
  int         m_len;
  bit         m_bits[$];

  function automatic bit model_hit();
    if (m_bits.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_armed = 0; m_op = 0; m_err = 0;
      m_cnt8 = 8'd0; m_sat8 = 0; m_cnt2 = 2'd0; m_sat2 = 0;
      m_pat = 8'b0000_1100; m_len = 4; m_ovl = 1; m_bits.delete();
    end else if (!m_armed) begin
      m_op = 0;
      if (cfg_we) begin
        if (cfg_len >= 4'd1 && cfg_len <= 4'd8) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_err = 0;
        end else begin
          m_err = 1;
        end
      end else begin
        m_err = 0;
        if (start) begin
          m_armed = 1; m_bits.delete();
          m_cnt8 = 8'd0; m_sat8 = 0; m_cnt2 = 2'd0; m_sat2 = 0;
        end
      end
    end else begin
      m_err = cfg_we;
      m_op  = 0;
      if (stop) begin
        m_armed = 0;
      end else if (ip_valid) begin
        m_bits.push_back(ip);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (model_hit()) begin
          m_op = 1;
          if (m_cnt8 == 8'hFF) m_sat8 = 1; else m_cnt8 = m_cnt8 + 8'd1;
          if (m_cnt2 == 2'd3) m_sat2 = 1; else m_cnt2 = m_cnt2 + 2'd1;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and compare both instances against the model
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("op",      int'(op_a),   int'(m_op));
    chk("busy",    int'(busy_a), int'(m_armed));
    chk("cfg_err", int'(err_a),  int'(m_err));
    chk("cnt",     int'(cnt_a),  int'(m_cnt8));
    chk("sat",     int'(sat_a),  int'(m_sat8));
    chk("op_b",    int'(op_b),   int'(m_op));
    chk("cnt_b",   int'(cnt_b),  int'(m_cnt2));
    chk("sat_b",   int'(sat_b),  int'(m_sat2));
    chk("err_b",   int'(err_b),  int'(m_err));
  endtask

  task automatic idle_in();
    cfg_we = 0; start = 0; stop = 0; ip = 0; ip_valid = 0; reset = 0;
  endtask

  task automatic do_reset();
    idle_in(); reset = 1; tick(); reset = 0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    idle_in(); cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; tick(); cfg_we = 0;
  endtask

  task automatic do_start();
    idle_in(); start = 1; tick(); start = 0;
  endtask

  task automatic do_stop();
    idle_in(); stop = 1; tick(); stop = 0;
  endtask

  // Feed a bit string (MSB first), returning the number of op pulses seen
  task automatic feed(input logic [15:0] bits, input int n, output int pulses);
    pulses = 0;
    for (int i = n - 1; i >= 0; i--) begin
      ip_valid = 1; ip = bits[i]; tick();
      pulses += int'(op_a);
    end
    ip_valid = 0;
  endtask

  int p;

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_cnt",  int'(cnt_a),  0);

    // T1: default 1100
    do_start();
    chk("t1_busy", int'(busy_a), 1);
    ip_valid = 1;
    ip = 1; tick(); ip = 1; tick(); ip = 0; tick();
    chk("t1_op_early", int'(op_a), 0);
    ip = 0; tick();
    chk("t1_op", int'(op_a), 1);
    chk("t1_cnt", int'(cnt_a), 1);
    ip_valid = 0; tick();
    chk("t1_op_one_cycle", int'(op_a), 0);

    // T2: 101 overlap vs non-overlap
    do_stop();
    do_cfg(8'b101, 4'd3, 1'b1);
    do_start();
    feed(16'b10101, 5, p);
    chk("t2_ovl_pulses", p, 2);
    chk("t2_ovl_cnt", int'(cnt_a), 2);
    do_stop();
    do_cfg(8'b101, 4'd3, 1'b0);
    do_start();
    feed(16'b10101, 5, p);
    chk("t2_novl_pulses", p, 1);
    chk("t2_novl_cnt", int'(cnt_a), 1);

    // T3: valid gap inside a partial match
    do_reset();
    do_start();
    feed(16'b11, 2, p);
    for (int i = 0; i < 3; i++) begin
      idle_in(); ip = 1; tick(); p += int'(op_a);
    end
    chk("t3_gap_pulses", p, 0);
    feed(16'b00, 2, p);
    chk("t3_pulses", p, 1);

    // T4: illegal length rejected; cfg write while running
    do_reset();
    do_cfg(8'b11, 4'd0, 1'b1);
    chk("t4_err_idle", int'(err_a), 1);
    idle_in(); tick();
    chk("t4_err_clear", int'(err_a), 0);
    do_start();
    ip_valid = 1; ip = 1; tick();
    cfg_we = 1; cfg_pattern = 8'b11; cfg_len = 4'd2; ip = 1; tick(); cfg_we = 0;
    chk("t4_err_run", int'(err_a), 1);
    chk("t4_no_op_11", int'(op_a), 0);
    feed(16'b00, 2, p);
    chk("t4_pulses", p, 1);

    // T5: stop coincident with final bit, then reset mid-stream
    do_reset();
    do_start();
    feed(16'b110, 3, p);
    ip_valid = 1; ip = 0; stop = 1; tick(); stop = 0; ip_valid = 0;
    chk("t5_stop_op", int'(op_a), 0);
    chk("t5_stop_cnt", int'(cnt_a), 0);
    chk("t5_stop_busy", int'(busy_a), 0);
    do_cfg(8'b11, 4'd2, 1'b1);
    do_start();
    feed(16'b11, 2, p);
    chk("t5_alt_pulses", p, 1);
    reset = 1; #1;
    chk("t5_async_busy", int'(busy_a), 0);
    chk("t5_async_cnt", int'(cnt_a), 0);
    chk("t5_async_op", int'(op_a), 0);
    tick(); reset = 0;
    do_start();
    feed(16'b11, 2, p);
    chk("t5_def_no_11", p, 0);
    feed(16'b00, 2, p);
    chk("t5_def_pulses", p, 1);

    // T6: saturation on the 2-bit instance
    do_reset();
    do_cfg(8'b1, 4'd1, 1'b1);
    do_start();
    feed(16'b11111, 5, p);
    chk("t6_pulses", p, 5);
    chk("t6_cnt_b", int'(cnt_b), 3);
    chk("t6_sat_b", int'(sat_b), 1);
    chk("t6_cnt_a", int'(cnt_a), 5);
    do_stop();
    chk("t6_hold_b", int'(cnt_b), 3);
    do_start();
    chk("t6_clr_cnt", int'(cnt_b), 0);
    chk("t6_clr_sat", int'(sat_b), 0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      cfg_we      = ($urandom_range(0, 19) == 0);
      cfg_pattern = 8'($urandom());
      cfg_len     = 4'($urandom_range(0, 9) > 5 ? $urandom_range(0, 9) : $urandom_range(1, 3));
      cfg_overlap = 1'($urandom());
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      ip_valid    = ($urandom_range(0, 3) != 0);
      ip          = 1'($urandom());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
